full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder.sv | 95 +++++++++
 tb/tb_full_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// One-bit full adder with a combinational result, a registered result and optional input statistics.
// Defining FULL_ADDER_STATS_EN enables the coverage map and the saturating carry-event counter.
module full_adder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             sum,
    output logic             cout,
    output logic             sum_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic [7:0]       cov_map,
    output logic             cov_full,
    output logic [CNT_W-1:0] carry_cnt
);

    logic sum_d;
    logic cout_d;
    logic out_valid_d;
    logic out_valid_q;

    // The combinational path never depends on clk, rst or in_valid.
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum;
            cout_d = cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef FULL_ADDER_STATS_EN
    logic [7:0]       cov_map_d;
    logic [7:0]       cov_map_q;
    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;
    logic [2:0]       combo_idx;

    assign combo_idx = {a, b, cin};

    // Coverage bits are sticky; the counter stops at all-ones instead of wrapping.
    always_comb begin
        cov_map_d   = cov_map_q;
        carry_cnt_d = carry_cnt_q;
        if (in_valid) begin
            cov_map_d[combo_idx] = 1'b1;
            if (cout && (carry_cnt_q != {CNT_W{1'b1}})) begin
                carry_cnt_d = carry_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_map_q   <= 8'h00;
            carry_cnt_q <= '0;
        end else begin
            cov_map_q   <= cov_map_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign cov_map   = cov_map_q;
    assign carry_cnt = carry_cnt_q;
`else
    assign cov_map   = 8'h00;
    assign carry_cnt = '0;
`endif

    assign cov_full = &cov_map;

endmodule

// File: tb/tb_full_adder.sv
// Randomised and directed bench for full_adder with an arithmetic reference model and result scoreboard.
// Works with or without FULL_ADDER_STATS_EN; a second instance with CNT_W=2 exercises counter saturation.
module tb_full_adder;

`ifdef FULL_ADDER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
    localparam int SAT_MAX_W  = 65535;
    localparam int SAT_MAX_2  = 3;

    logic        clk;
    logic        rst;
    logic        a;
    logic        b;
    logic        cin;
    logic        in_valid;
    logic        sum;
    logic        cout;
    logic        sum_q;
    logic        cout_q;
    logic        out_valid;
    logic [7:0]  cov_map;
    logic        cov_full;
    logic [15:0] carry_cnt;
    logic        s_sum;
    logic        s_cout;
    logic        s_sum_q;
    logic        s_cout_q;
    logic        s_out_valid;
    logic [7:0]  s_cov_map;
    logic        s_cov_full;
    logic [1:0]  s_carry_cnt;

    full_adder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q), .out_valid(out_valid),
        .cov_map(cov_map), .cov_full(cov_full), .carry_cnt(carry_cnt)
    );

    full_adder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(s_sum), .cout(s_cout), .sum_q(s_sum_q), .cout_q(s_cout_q), .out_valid(s_out_valid),
        .cov_map(s_cov_map), .cov_full(s_cov_full), .carry_cnt(s_carry_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // scoreboard state: expected registered results and reference statistics
    logic [1:0] exp_q[$];
    bit         seen[8];
    int         cnt_model;
    int         cnt_sat_model;
    logic [1:0] last_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seen_map();
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) if (seen[i]) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_stats();
        logic [7:0] m;
        m = STATS_EN ? seen_map() : 8'h00;
        check("cov_map", {24'd0, cov_map}, {24'd0, m});
        check("cov_full", {31'd0, cov_full}, {31'd0, (m == 8'hFF)});
        check("carry_cnt", {16'd0, carry_cnt}, STATS_EN ? cnt_model : 0);
        check("carry_cnt_sat", {30'd0, s_carry_cnt}, STATS_EN ? cnt_sat_model : 0);
    endtask

    task automatic check_comb();
        int total;
        total = int'(a) + int'(b) + int'(cin);
        check("comb_result", {30'd0, cout, sum}, total);
        check("comb_result_sat", {30'd0, s_cout, s_sum}, total);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        cnt_model     = 0;
        cnt_sat_model = 0;
        last_res      = 2'b00;
        exp_q.delete();
    endfunction

    // driver: present one input beat, let a clock edge pass, check the registered side
    task automatic issue(input logic va, input logic vb, input logic vc, input logic vv);
        int total;
        a = va; b = vb; cin = vc; in_valid = vv;
        total = int'(va) + int'(vb) + int'(vc);
        #1;
        check_comb();
        if (vv) begin
            last_res = 2'(total);
            exp_q.push_back(2'(total));
            seen[{va, vb, vc}] = 1'b1;
            if (total >= 2) begin
                if (cnt_model < SAT_MAX_W) cnt_model++;
                if (cnt_sat_model < SAT_MAX_2) cnt_sat_model++;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, vv});
        check("reg_result", {30'd0, cout_q, sum_q}, {30'd0, last_res});
        check_stats();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_reg_result", {30'd0, cout_q, sum_q}, 0);
        check("rst_cov_map", {24'd0, cov_map}, 0);
        check("rst_cov_full", {31'd0, cov_full}, 0);
        check("rst_carry_cnt", {16'd0, carry_cnt}, 0);
        check("rst_carry_cnt_sat", {30'd0, s_carry_cnt}, 0);
        a = 1'b1; b = 1'b0; cin = 1'b1;
        #1;
        check_comb();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // monitor: pop one expectation per presented result
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %0d with no pending result at %0t", {cout_q, sum_q}, $time);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("sb_result", {30'd0, cout_q, sum_q}, {30'd0, e});
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0; in_valid = 1'b0;
        #3;
        check("init_out_valid", {31'd0, out_valid}, 0);
        check("init_reg_result", {30'd0, cout_q, sum_q}, 0);
        check_stats();

        // combinational sweep at 5 ns spacing, no valid
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            #1;
            check_comb();
            #4;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1'b1, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 1'b0);

        // full valid sweep: coverage fills, four carry events
        for (int i = 0; i < 8; i++) issue(i[2], i[1], i[0], 1'b1);
        issue(1'b0, 1'b0, 1'b0, 1'b0);

        mid_reset();
        for (int i = 0; i < 5; i++) issue(1'b1, 1'b1, 1'b1, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            if (n == 120) begin
                issue(1'b0, 1'b0, 1'b0, 1'b0);
                mid_reset();
            end
        end
        issue(1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
